// File: rtl/sobel_frame_ctrl_if.sv
// rtl/sobel_frame_ctrl_if.sv - source read, kernel stream and destination write bundle for sobel_frame_ctrl
interface sobel_frame_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [7:0]        rd_data_i;
  logic [7:0]        k_pix_o;
  logic              k_vld_o;
  logic [7:0]        k_pix_i;
  logic              k_vld_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;

  modport master (
    output rd_en_o, rd_addr_o,
    input  rd_data_i,
    output k_pix_o, k_vld_o,
    input  k_pix_i, k_vld_i,
    output wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  rd_en_o, rd_addr_o,
    output rd_data_i,
    input  k_pix_o, k_vld_o,
    output k_pix_i, k_vld_i,
    input  wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame sequencer feeding the Sobel kernel and storing its results
// Optional DRAIN watchdog enabled by defining SOBEL_CTRL_WATCHDOG_EN.
module sobel_frame_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 19,
  parameter int OUT_COUNT = (IMG_W - 2) * (IMG_H - 2),
  parameter int LINE_GAP  = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               err_o,
  sobel_frame_ctrl_if.master fb
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
  localparam logic [GW-1:0]     GAP_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [ADDR_W-1:0] OUT_N    = ADDR_W'(OUT_COUNT);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [GW-1:0]     gap_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              k_vld_q;
  logic [7:0]        k_pix_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [ADDR_W-1:0] res_cnt_q, res_cnt_d;
  logic              busy_q, done_q, err_q;
  logic              capture, row_end, last_px, wd_expire;

  always_comb begin
    capture   = 1'b0;
    row_end   = (col_q == COL_LAST);
    last_px   = row_end && (row_q == ROW_LAST);
    if ((state_q == S_FEED) || (state_q == S_GAP) || (state_q == S_DRAIN))
      capture = fb.k_vld_i && (res_cnt_q < OUT_N);
    res_cnt_d = res_cnt_q + {{(ADDR_W-1){1'b0}}, capture};
  end

`ifdef SOBEL_CTRL_WATCHDOG_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wd_q;

  // Any kernel strobe in DRAIN, even a surplus one, proves the kernel is alive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wd_q <= '0;
    else if ((state_q != S_DRAIN) || fb.k_vld_i)
      wd_q <= '0;
    else if (wd_q != TO_LAST)
      wd_q <= wd_q + TW'(1);
  end

  assign wd_expire = (state_q == S_DRAIN) && !fb.k_vld_i && (wd_q == TO_LAST);
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      gap_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      k_vld_q   <= 1'b0;
      k_pix_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      res_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      k_vld_q   <= rd_en_q;
      k_pix_q   <= fb.rd_data_i;
      wr_en_q   <= capture;
      res_cnt_q <= res_cnt_d;
      done_q    <= 1'b0;
      if (capture) begin
        wr_addr_q <= res_cnt_q;
        wr_data_q <= fb.k_pix_i;
      end

      if (abort_i && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        rd_en_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_q   <= S_FEED;
              col_q     <= '0;
              row_q     <= '0;
              rd_addr_q <= '0;
              res_cnt_q <= '0;
              err_q     <= 1'b0;
              rd_en_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          S_FEED: begin
            // The address holds at the last pixel so it never wraps.
            if (last_px) begin
              state_q <= S_DRAIN;
              rd_en_q <= 1'b0;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
              if (row_end) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
                if (LINE_GAP > 0) begin
                  state_q <= S_GAP;
                  rd_en_q <= 1'b0;
                  gap_q   <= '0;
                end
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
          S_GAP: begin
            if (gap_q == GAP_LAST) begin
              state_q <= S_FEED;
              rd_en_q <= 1'b1;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          S_DRAIN: begin
            if (res_cnt_d == OUT_N) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (wd_expire) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign err_o        = err_q;
  assign fb.rd_en_o   = rd_en_q;
  assign fb.rd_addr_o = rd_addr_q;
  assign fb.k_vld_o   = k_vld_q;
  assign fb.k_pix_o   = k_pix_q;
  assign fb.wr_en_o   = wr_en_q;
  assign fb.wr_addr_o = wr_addr_q;
  assign fb.wr_data_o = wr_data_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - directed self-checking bench for sobel_frame_ctrl
module tb_sobel_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int OC = 2;

  logic clk = 1'b0;
  logic rst;
  logic start_a, abort_a, start_b, abort_b;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [7:0] src [0:15];
  int tests = 0;
  int fails = 0;
  int kv;
  logic exp_en;
  int exp_addr;

  sobel_frame_ctrl_if #(.ADDR_W(AW)) ifa ();
  sobel_frame_ctrl_if #(.ADDR_W(AW)) ifb ();

  sobel_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_COUNT(OC), .LINE_GAP(0), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a),
    .busy_o(busy_a), .frame_done_o(done_a), .err_o(err_a), .fb(ifa.master)
  );

  sobel_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_COUNT(OC), .LINE_GAP(2), .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b),
    .busy_o(busy_b), .frame_done_o(done_b), .err_o(err_b), .fb(ifb.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifa.rd_data_i <= src[ifa.rd_addr_o];
    ifb.rd_data_i <= src[ifb.rd_addr_o];
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) src[i] = 8'(8'h30 + i);
    rst = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    ifa.k_vld_i = 1'b0; ifa.k_pix_i = 8'h00;
    ifb.k_vld_i = 1'b0; ifb.k_pix_i = 8'h00;
    step(); step();
    chk("rst_busy", busy_a, 0);
    chk("rst_rd_en", ifa.rd_en_o, 0);
    chk("rst_rd_addr", ifa.rd_addr_o, 0);
    chk("rst_k_vld", ifa.k_vld_o, 0);
    chk("rst_wr_en", ifa.wr_en_o, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    rst = 1'b1;
    step();

    // basic frame
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("basic_rd_en", ifa.rd_en_o, 1);
      chk("basic_rd_addr", ifa.rd_addr_o, i);
      chk("basic_busy", busy_a, 1);
      chk("basic_k_vld", ifa.k_vld_o, (i > 0) ? 1 : 0);
      if (i >= 2) chk("basic_k_pix", ifa.k_pix_o, src[i-2]);
      step();
    end
    chk("drain_rd_en", ifa.rd_en_o, 0);
    chk("drain_k_vld_last", ifa.k_vld_o, 1);
    chk("drain_busy", busy_a, 1);
    ifa.k_vld_i = 1'b1; ifa.k_pix_i = 8'hA5; step();
    chk("res0_wr_en", ifa.wr_en_o, 1);
    chk("res0_wr_addr", ifa.wr_addr_o, 0);
    chk("res0_wr_data", ifa.wr_data_o, 8'hA5);
    chk("res0_done", done_a, 0);
    chk("res0_k_vld", ifa.k_vld_o, 0);
    chk("res0_k_pix_last", ifa.k_pix_o, src[11]);
    ifa.k_pix_i = 8'h5A; step();
    chk("res1_wr_addr", ifa.wr_addr_o, 1);
    chk("res1_wr_data", ifa.wr_data_o, 8'h5A);
    chk("res1_done", done_a, 1);
    chk("res1_busy", busy_a, 0);
    ifa.k_vld_i = 1'b0; start_a = 1'b1; step(); start_a = 1'b0;
    chk("done_pulse_end", done_a, 0);
    chk("start_in_done_ignored", busy_a, 0);
    chk("idle_wr_en", ifa.wr_en_o, 0);
    ifa.k_vld_i = 1'b1; step(); ifa.k_vld_i = 1'b0;
    chk("idle_result_dropped", ifa.wr_en_o, 0);
    chk("idle_rd_en", ifa.rd_en_o, 0);

    // early completion plus one surplus result
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("early_rd_addr", ifa.rd_addr_o, i);
      chk("early_wr_en", ifa.wr_en_o, (i == 4 || i == 5) ? 1 : 0);
      if (i == 4 || i == 5) begin
        chk("early_wr_addr", ifa.wr_addr_o, i - 4);
        chk("early_wr_data", ifa.wr_data_o, 8'hC0 + i - 1);
      end
      ifa.k_vld_i = (i >= 3 && i <= 5);
      ifa.k_pix_i = 8'(8'hC0 + i);
      step();
    end
    chk("early_drain_busy", busy_a, 1);
    chk("early_drain_done", done_a, 0);
    step();
    chk("early_done", done_a, 1);
    chk("early_busy_drop", busy_a, 0);
    step();
    chk("early_done_end", done_a, 0);

    // abort at address 5
    start_a = 1'b1; step(); start_a = 1'b0;
    repeat (5) step();
    chk("abort_at_addr", ifa.rd_addr_o, 5);
    abort_a = 1'b1; step(); abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_rd_en", ifa.rd_en_o, 0);
    chk("abort_inflight_k_vld", ifa.k_vld_o, 1);
    chk("abort_done", done_a, 0);
    step();
    chk("abort_k_vld_end", ifa.k_vld_o, 0);
    chk("abort_no_done", done_a, 0);
    repeat (3) step();
    chk("abort_stays_idle", ifa.rd_en_o, 0);

    // restart after abort, result count back at 0
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("restart_addr", ifa.rd_addr_o, 0);
    chk("restart_rd_en", ifa.rd_en_o, 1);
    repeat (12) step();
    chk("restart_drain_busy", busy_a, 1);
    ifa.k_vld_i = 1'b1; ifa.k_pix_i = 8'h77; step(); ifa.k_vld_i = 1'b0;
    chk("restart_wr_addr", ifa.wr_addr_o, 0);
    chk("restart_wr_data", ifa.wr_data_o, 8'h77);

    // reset mid-DRAIN
    rst = 1'b0; #1;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_rd_addr", ifa.rd_addr_o, 0);
    chk("mrst_k_vld", ifa.k_vld_o, 0);
    chk("mrst_wr_en", ifa.wr_en_o, 0);
    chk("mrst_wr_addr", ifa.wr_addr_o, 0);
    chk("mrst_wr_data", ifa.wr_data_o, 0);
    chk("mrst_done", done_a, 0);
    step(); rst = 1'b1; step();
    chk("mrst_idle", busy_a, 0);

    // start while busy is ignored
    start_a = 1'b1; step(); start_a = 1'b0;
    repeat (3) step();
    chk("busy_start_pre", ifa.rd_addr_o, 3);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("busy_start_ignored", ifa.rd_addr_o, 4);
    repeat (8) step();
    chk("wd_drain_rd_en", ifa.rd_en_o, 0);
    chk("wd_drain_busy", busy_a, 1);
    ifa.k_vld_i = 1'b1; ifa.k_pix_i = 8'h42; step(); ifa.k_vld_i = 1'b0;
    chk("wd_single_result", ifa.wr_addr_o, 0);
    repeat (7) step();
    chk("wd_silent7_busy", busy_a, 1);
    chk("wd_silent7_err", err_a, 0);
    step();
`ifdef SOBEL_CTRL_WATCHDOG_EN
    chk("wd_done", done_a, 1);
    chk("wd_err", err_a, 1);
    chk("wd_busy", busy_a, 0);
    step();
    chk("wd_done_end", done_a, 0);
    repeat (2) step();
    chk("wd_err_sticky", err_a, 1);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("wd_err_cleared", err_a, 0);
    chk("wd_restart_busy", busy_a, 1);
    abort_a = 1'b1; step(); abort_a = 1'b0;
`else
    chk("nowd_no_done", done_a, 0);
    chk("nowd_no_err", err_a, 0);
    repeat (20) step();
    chk("nowd_still_drain", busy_a, 1);
    chk("nowd_err_low", err_a, 0);
    abort_a = 1'b1; step(); abort_a = 1'b0;
    chk("nowd_abort_drain", busy_a, 0);
`endif

    // line gap of 2 on the second instance
    start_b = 1'b1; step(); start_b = 1'b0;
    kv = 0;
    for (int c = 0; c < 18; c++) begin
      exp_en = 1'b0; exp_addr = 0;
      if (c < 4)       begin exp_en = 1'b1; exp_addr = c;     end
      else if (c < 6)  exp_en = 1'b0;
      else if (c < 10) begin exp_en = 1'b1; exp_addr = c - 2; end
      else if (c < 12) exp_en = 1'b0;
      else if (c < 16) begin exp_en = 1'b1; exp_addr = c - 4; end
      chk("gap_rd_en", ifb.rd_en_o, exp_en);
      if (exp_en) chk("gap_rd_addr", ifb.rd_addr_o, exp_addr);
      kv += int'(ifb.k_vld_o);
      step();
    end
    chk("gap_k_vld_count", kv, 12);
    chk("gap_drain_busy", busy_b, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
